// File: rtl/and_gate_dataflow_if.sv
// Operand/result bundle for the and_gate_dataflow cell.
// The master drives the operands and counter clear; the slave returns the results and debug side-band.
interface and_gate_dataflow_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_clr;
    logic [WIDTH-1:0] o_y;
    logic [WIDTH-1:0] o_y_q;
    logic             o_y_all;
    logic             o_y_any;
    logic             o_rise;
    logic [CNT_W-1:0] o_high_cnt;
    logic [CNT_W-1:0] o_rise_cnt;

    modport master (
        output i_a, i_b, i_clr,
        input  o_y, o_y_q, o_y_all, o_y_any, o_rise, o_high_cnt, o_rise_cnt
    );

    modport slave (
        input  i_a, i_b, i_clr,
        output o_y, o_y_q, o_y_all, o_y_any, o_rise, o_high_cnt, o_rise_cnt
    );
endinterface

// File: rtl/and_gate_dataflow.sv
// Bitwise AND cell with a zero-latency result, plus a registered side-band:
// a delayed copy of the result, a rising-edge pulse on the all-ones flag and saturating activity counters.
module and_gate_dataflow #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    and_gate_dataflow_if.slave bus
);

    logic [WIDTH-1:0] w_y;
    logic             w_all;
    logic             w_any;
    logic             w_rise_cond;
    logic             w_high_sat;
    logic             w_rise_sat;

    logic [WIDTH-1:0] r_y_q;
    logic             r_prev_all;
    logic             r_rise;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_rise_cnt;

    // The dataflow path never touches clk or rst, so it stays valid through reset and with the clock stopped.
    assign w_y         = bus.i_a & bus.i_b;
    assign w_all       = &w_y;
    assign w_any       = |w_y;
    assign w_rise_cond = w_all & ~r_prev_all;
    assign w_high_sat  = &r_high_cnt;
    assign w_rise_sat  = &r_rise_cnt;

    // Clear only zeroes the counters and beats a same-edge increment; reset beats everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q      <= '0;
            r_prev_all <= 1'b0;
            r_rise     <= 1'b0;
            r_high_cnt <= '0;
            r_rise_cnt <= '0;
        end else begin
            r_y_q      <= w_y;
            r_prev_all <= w_all;
            r_rise     <= w_rise_cond;
            if (bus.i_clr) begin
                r_high_cnt <= '0;
                r_rise_cnt <= '0;
            end else begin
                if (w_all && !w_high_sat) begin
                    r_high_cnt <= r_high_cnt + CNT_W'(1);
                end
                if (w_rise_cond && !w_rise_sat) begin
                    r_rise_cnt <= r_rise_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.o_y        = w_y;
    assign bus.o_y_all    = w_all;
    assign bus.o_y_any    = w_any;
    assign bus.o_y_q      = r_y_q;
    assign bus.o_rise     = r_rise;
    assign bus.o_high_cnt = r_high_cnt;
    assign bus.o_rise_cnt = r_rise_cnt;

endmodule

// File: tb/tb_and_gate_dataflow.sv
// Directed bench for and_gate_dataflow: a 1-bit cell with wide counters and a 4-bit cell with 3-bit counters.
// Expected values are hand-computed constants or small saturating arithmetic.
module tb_and_gate_dataflow;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    and_gate_dataflow_if #(.WIDTH(1), .CNT_W(16)) bus1 ();
    and_gate_dataflow_if #(.WIDTH(4), .CNT_W(3))  bus4 ();

    and_gate_dataflow #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    and_gate_dataflow #(.WIDTH(4), .CNT_W(3)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic clr);
        bus1.i_a   = a;
        bus1.i_b   = b;
        bus1.i_clr = clr;
    endtask

    task automatic applyWideStimulus(input logic [3:0] a, input logic [3:0] b, input logic clr);
        bus4.i_a   = a;
        bus4.i_b   = b;
        bus4.i_clr = clr;
    endtask

    // Step to just after the next rising edge so registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] ttAb   [8];
    logic       ttY    [8];
    logic       ttRise [8];
    logic       bX;
    int         expHigh;

    initial begin
        checkCount = 0;
        errorCount = 0;
        ttAb   = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b11};
        ttY    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ttRise = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        $display("[TB] reset hold");
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyWideStimulus(4'b0000, 4'b0000, 1'b0);
        #1;
        checkOutput("y_in_reset", 32'(bus1.o_y), 32'd1);
        checkOutput("y_all_in_reset", 32'(bus1.o_y_all), 32'd1);
        repeat (3) tick();
        checkOutput("y_q_reset", 32'(bus1.o_y_q), 32'd0);
        checkOutput("rise_reset", 32'(bus1.o_rise), 32'd0);
        checkOutput("high_cnt_reset", 32'(bus1.o_high_cnt), 32'd0);
        checkOutput("rise_cnt_reset", 32'(bus1.o_rise_cnt), 32'd0);

        rst = 1'b0;
        tick();
        checkOutput("y_q_release", 32'(bus1.o_y_q), 32'd1);
        checkOutput("rise_release", 32'(bus1.o_rise), 32'd1);
        checkOutput("high_cnt_release", 32'(bus1.o_high_cnt), 32'd1);
        checkOutput("rise_cnt_release", 32'(bus1.o_rise_cnt), 32'd1);
        tick();
        checkOutput("rise_one_cycle", 32'(bus1.o_rise), 32'd0);
        checkOutput("high_cnt_second", 32'(bus1.o_high_cnt), 32'd2);
        checkOutput("rise_cnt_second", 32'(bus1.o_rise_cnt), 32'd1);

        $display("[TB] truth table and edge counting");
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(ttAb[i][1], ttAb[i][0], 1'b0);
            #1;
            checkOutput($sformatf("tt_y_%0d", i), 32'(bus1.o_y), 32'(ttY[i]));
            checkOutput($sformatf("tt_all_%0d", i), 32'(bus1.o_y_all), 32'(ttY[i]));
            checkOutput($sformatf("tt_any_%0d", i), 32'(bus1.o_y_any), 32'(ttY[i]));
            tick();
            checkOutput($sformatf("tt_y_q_%0d", i), 32'(bus1.o_y_q), 32'(ttY[i]));
            checkOutput($sformatf("tt_rise_%0d", i), 32'(bus1.o_rise), 32'(ttRise[i]));
        end
        checkOutput("tt_high_cnt", 32'(bus1.o_high_cnt), 32'd3);
        checkOutput("tt_rise_cnt", 32'(bus1.o_rise_cnt), 32'd3);

        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("gap_high_cnt", 32'(bus1.o_high_cnt), 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput($sformatf("hold_rise_%0d", k), 32'(bus1.o_rise), (k == 1) ? 32'd1 : 32'd0);
        end
        checkOutput("hold_high_cnt", 32'(bus1.o_high_cnt), 32'd8);
        checkOutput("hold_rise_cnt", 32'(bus1.o_rise_cnt), 32'd4);

        $display("[TB] reset mid-operation beats clear");
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("mid_y_q", 32'(bus1.o_y_q), 32'd0);
        checkOutput("mid_rise", 32'(bus1.o_rise), 32'd0);
        checkOutput("mid_high_cnt", 32'(bus1.o_high_cnt), 32'd0);
        checkOutput("mid_rise_cnt", 32'(bus1.o_rise_cnt), 32'd0);
        checkOutput("mid_y_comb", 32'(bus1.o_y), 32'd1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] unknown operand");
        bus1.i_a = 1'b0;
        bus1.i_b = 1'bx;
        #1;
        checkOutput("x_masked", 32'(bus1.o_y), 32'd0);
        bX = 1'bx;
        bus1.i_a = 1'b1;
        bus1.i_b = bX;
        #1;
        checkOutput("x_passed", 32'(bus1.o_y), 32'(bX));
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] wide reductions");
        applyWideStimulus(4'b1111, 4'b1010, 1'b0);
        #1;
        checkOutput("w_y", 32'(bus4.o_y), 32'hA);
        checkOutput("w_all_0", 32'(bus4.o_y_all), 32'd0);
        checkOutput("w_any_1", 32'(bus4.o_y_any), 32'd1);
        tick();
        checkOutput("w_y_q", 32'(bus4.o_y_q), 32'hA);
        applyWideStimulus(4'b1111, 4'b1111, 1'b0);
        #1;
        checkOutput("w_all_1", 32'(bus4.o_y_all), 32'd1);
        tick();
        applyWideStimulus(4'b0000, 4'b1111, 1'b0);
        #1;
        checkOutput("w_any_0", 32'(bus4.o_y_any), 32'd0);
        checkOutput("w_all_off", 32'(bus4.o_y_all), 32'd0);
        tick();

        $display("[TB] saturation and clear");
        applyWideStimulus(4'b1111, 4'b1111, 1'b1);
        tick();
        checkOutput("clr_high_cnt", 32'(bus4.o_high_cnt), 32'd0);
        checkOutput("clr_rise_cnt", 32'(bus4.o_rise_cnt), 32'd0);
        checkOutput("clr_keeps_rise", 32'(bus4.o_rise), 32'd1);
        applyWideStimulus(4'b1111, 4'b1111, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            expHigh = (k > 7) ? 7 : k;
            checkOutput($sformatf("sat_high_%0d", k), 32'(bus4.o_high_cnt), 32'(expHigh));
        end
        checkOutput("sat_rise_cnt", 32'(bus4.o_rise_cnt), 32'd0);
        applyWideStimulus(4'b1111, 4'b1111, 1'b1);
        tick();
        checkOutput("clr_wins", 32'(bus4.o_high_cnt), 32'd0);
        checkOutput("clr_y_q", 32'(bus4.o_y_q), 32'hF);
        applyWideStimulus(4'b1111, 4'b1111, 1'b0);
        tick();
        checkOutput("after_clr", 32'(bus4.o_high_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/and_gate_dataflow.md
Name: and_gate_dataflow

Overview:
- Bitwise AND primitive with a zero-latency dataflow output, used as the basic gating cell in datapath and glue logic.
- The combinational path is clock- and reset-independent.
- A registered side-band adds:
  - a pipelined copy of the result;
  - reduction flags;
  - rising-edge detection;
  - saturating activity counters, for debug and coverage visibility.
- Single clock domain.

Parameters:
- WIDTH, 1, bit width of operands a, b and result y.
- CNT_W, 16, width of each saturating counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; synchronous, active-high. Sampled on rising clk.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- clr  input  1  synchronous clear of both counters; does not affect other state.
- y  output  WIDTH  combinational result, a & b.
- y_q  output  WIDTH  y registered one cycle.
- y_all  output  1  combinational AND-reduction of y.
- y_any  output  1  combinational OR-reduction of y.
- rise  output  1  registered one-cycle pulse when y_all goes 0 -> 1.
- high_cnt  output  CNT_W  number of clock edges that sampled y_all=1 (saturating).
- rise_cnt  output  CNT_W  number of rise pulses issued (saturating).

Behaviour:
- Dataflow path:
  - y = a & b, bitwise, continuous assignment, zero latency.
  - y is valid during reset and with clk stopped.
  - Standard 4-state semantics: 0&x=0, 1&x=x.
- y_all = &y and y_any = |y. Both are combinational with zero latency.
- Reset: on a rising clk with rst=1, all registers go to 0: y_q, rise, high_cnt, rise_cnt, and the internal previous-value register prev_all.
- Reset priority: rst has priority over clr and all counting.
- Registered path, each rising clk with rst=0:
  - y_q <= y.
  - prev_all <= y_all.
  - rise <= y_all & ~prev_all, so rise asserts in the cycle after the edge where y_all is first sampled high, and lasts one cycle.
  - high_cnt increments by 1 when y_all=1.
  - rise_cnt increments by 1 when y_all & ~prev_all.
- Latency: y_q, rise and both counters update one clock after the sampled condition.
- Saturation: a counter at all-ones (2^CNT_W-1) holds and never wraps.
- clr=1 (rst=0): both counters load 0 on that edge. The increment condition on that same edge is ignored (clear wins).
- clr does not affect y_q, rise or prev_all.
- Reset mid-operation: registered outputs go to 0 on the reset edge. The combinational y, y_all and y_any keep tracking a & b.
- First edge after reset release with y_all=1: counts as a rise, because prev_all=0.
- y_all held high for N edges: exactly one rise pulse, and high_cnt increases by N.
- WIDTH=1: y_all = y_any = y.

Test Plan:
- Truth table, WIDTH=1, inputs changed every 10 ns, clk free-running:
  - ab=00,01,10,11,01,11,00,11 -> y=0,0,0,1,0,1,0,1.
  - Each y value valid immediately after its input change; no clock dependency.
- Reset hold:
  - rst=1 for 3 edges with a=b=1 -> y=1, y_all=1; y_q=0, rise=0, counters=0.
  - Release rst -> next edge: y_q=1, rise=1, high_cnt=1, rise_cnt=1.
- Edge and count, WIDTH=1, 10 ns clk:
  - Drive the truth-table sequence sampled once per clock -> rise_cnt=3, high_cnt=3, one-cycle rise pulse after each 0->1 of y.
  - Holding ab=11 for 5 edges -> high_cnt +5, rise_cnt +1.
- WIDTH=4 reductions:
  - a=4'b1111, b=4'b1010 -> y=1010, y_all=0, y_any=1.
  - b=4'b1111 -> y_all=1.
  - a=4'b0000 -> y_any=0.
- Saturation, CNT_W=3:
  - Hold y_all=1 for 10 edges -> high_cnt reaches 7 and stays 7.
  - Assert clr for one edge with y_all=1 -> high_cnt=0 (not 1).
- X handling:
  - a=0, b=x -> y=0.
  - a=1, b=x -> y=x.
